// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with execute-stage operand forwarding and selection
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int ALUC_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stallE,
  input  logic              flushE,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] SignImmD,
  input  logic [REG_W-1:0]  rsD,
  input  logic [REG_W-1:0]  rtD,
  input  logic [REG_W-1:0]  rdD,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              MemWriteD,
  input  logic              ALUSrcD,
  input  logic              RegDstD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic [1:0]        forwardAE,
  input  logic [1:0]        forwardBE,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] ResultW,
  output logic [REG_W-1:0]  rsE,
  output logic [REG_W-1:0]  rtE,
  output logic [REG_W-1:0]  WriteRegE,
  output logic [DATA_W-1:0] SrcAE,
  output logic [DATA_W-1:0] SrcBE,
  output logic [DATA_W-1:0] WriteDataE,
  output logic              RegWriteE,
  output logic              MemtoRegE,
  output logic              MemWriteE,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic              validE
);

  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic              regwrite_q, regwrite_d, memtoreg_q, memtoreg_d, memwrite_q, memwrite_d;
  logic              alusrc_q, alusrc_d, regdst_q, regdst_d, valid_q, valid_d;
  logic [ALUC_W-1:0] aluc_q, aluc_d;

  // Next-state: flush clears everything to a register-0 bubble, stall holds, else load Decode
  always_comb begin
    rd1_d      = rd1_q;
    rd2_d      = rd2_q;
    imm_d      = imm_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rd_d       = rd_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    memwrite_d = memwrite_q;
    alusrc_d   = alusrc_q;
    regdst_d   = regdst_q;
    aluc_d     = aluc_q;
    valid_d    = valid_q;
    if (flushE) begin
      rd1_d      = '0;
      rd2_d      = '0;
      imm_d      = '0;
      rs_d       = '0;
      rt_d       = '0;
      rd_d       = '0;
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      memwrite_d = 1'b0;
      alusrc_d   = 1'b0;
      regdst_d   = 1'b0;
      aluc_d     = '0;
      valid_d    = 1'b0;
    end else if (!stallE) begin
      rd1_d      = RD1D;
      rd2_d      = RD2D;
      imm_d      = SignImmD;
      rs_d       = rsD;
      rt_d       = rtD;
      rd_d       = rdD;
      regwrite_d = RegWriteD;
      memtoreg_d = MemtoRegD;
      memwrite_d = MemWriteD;
      alusrc_d   = ALUSrcD;
      regdst_d   = RegDstD;
      aluc_d     = ALUControlD;
      valid_d    = 1'b1;
    end
  end

  // E-stage state register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
      aluc_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      imm_q      <= imm_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rd_q       <= rd_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memwrite_q <= memwrite_d;
      alusrc_q   <= alusrc_d;
      regdst_q   <= regdst_d;
      aluc_q     <= aluc_d;
      valid_q    <= valid_d;
    end
  end

  // Forwarding muxes; code 11 is reserved and falls back to the register value
  always_comb begin
    case (forwardAE)
      2'b10:   SrcAE = ALUOutM;
      2'b01:   SrcAE = ResultW;
      default: SrcAE = rd1_q;
    endcase
    case (forwardBE)
      2'b10:   WriteDataE = ALUOutM;
      2'b01:   WriteDataE = ResultW;
      default: WriteDataE = rd2_q;
    endcase
  end

  // Immediate bypasses forwarding; destination picked by instruction format
  assign SrcBE       = alusrc_q ? imm_q : WriteDataE;
  assign WriteRegE   = regdst_q ? rd_q : rt_q;
  assign rsE         = rs_q;
  assign rtE         = rt_q;
  assign RegWriteE   = regwrite_q;
  assign MemtoRegE   = memtoreg_q;
  assign MemWriteE   = memwrite_q;
  assign ALUControlE = aluc_q;
  assign validE      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage with behavioural model and random stimulus
module tb_id_ex_stage;

  logic        clk, rst_n, stallE, flushE;
  logic [31:0] RD1D, RD2D, SignImmD, ALUOutM, ResultW;
  logic [4:0]  rsD, rtD, rdD;
  logic        RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD;
  logic [2:0]  ALUControlD;
  logic [1:0]  forwardAE, forwardBE;
  logic [4:0]  rsE, rtE, WriteRegE;
  logic [31:0] SrcAE, SrcBE, WriteDataE;
  logic        RegWriteE, MemtoRegE, MemWriteE, validE;
  logic [2:0]  ALUControlE;

  int errors = 0;
  int checks = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stallE(stallE), .flushE(flushE),
    .RD1D(RD1D), .RD2D(RD2D), .SignImmD(SignImmD),
    .rsD(rsD), .rtD(rtD), .rdD(rdD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .ALUControlD(ALUControlD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .ALUOutM(ALUOutM), .ResultW(ResultW),
    .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .WriteDataE(WriteDataE),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUControlE(ALUControlE), .validE(validE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the instruction held in E: one record, cleared by reset or flush
  typedef struct {
    logic [31:0] a, b, imm;
    logic [4:0]  rs, rt, rd;
    logic        regwrite, memtoreg, memwrite, alusrc, regdst, valid;
    logic [2:0]  aluc;
  } instr_t;

  instr_t m;

  function automatic instr_t bubble();
    instr_t z;
    z.a = 0; z.b = 0; z.imm = 0; z.rs = 0; z.rt = 0; z.rd = 0;
    z.regwrite = 0; z.memtoreg = 0; z.memwrite = 0; z.alusrc = 0; z.regdst = 0;
    z.valid = 0; z.aluc = 0;
    return z;
  endfunction

  function automatic instr_t from_decode();
    instr_t n;
    n.a = RD1D; n.b = RD2D; n.imm = SignImmD; n.rs = rsD; n.rt = rtD; n.rd = rdD;
    n.regwrite = RegWriteD; n.memtoreg = MemtoRegD; n.memwrite = MemWriteD;
    n.alusrc = ALUSrcD; n.regdst = RegDstD; n.aluc = ALUControlD; n.valid = 1'b1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        m <= bubble();
    else if (flushE)   m <= bubble();
    else if (!stallE)  m <= from_decode();
  end

  function automatic logic [31:0] pick(logic [1:0] f, logic [31:0] own);
    if (f == 2'b10) return ALUOutM;
    if (f == 2'b01) return ResultW;
    return own;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge: compare all outputs with the model
  always @(negedge clk) begin
    logic [31:0] wd;
    wd = pick(forwardBE, m.b);
    chk("SrcAE", SrcAE, pick(forwardAE, m.a));
    chk("WriteDataE", WriteDataE, wd);
    chk("SrcBE", SrcBE, m.alusrc ? m.imm : wd);
    chk("WriteRegE", 32'(WriteRegE), 32'(m.regdst ? m.rd : m.rt));
    chk("rsE", 32'(rsE), 32'(m.rs));
    chk("rtE", 32'(rtE), 32'(m.rt));
    chk("ctrl", {28'd0, RegWriteE, MemtoRegE, MemWriteE, validE},
        {28'd0, m.regwrite, m.memtoreg, m.memwrite, m.valid});
    chk("ALUControlE", 32'(ALUControlE), 32'(m.aluc));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_decode();
    RD1D = $urandom; RD2D = $urandom; SignImmD = $urandom;
    rsD = 5'($urandom); rtD = 5'($urandom); rdD = 5'($urandom);
    RegWriteD = 1'($urandom); MemtoRegD = 1'($urandom); MemWriteD = 1'($urandom);
    ALUSrcD = 1'($urandom); RegDstD = 1'($urandom); ALUControlD = 3'($urandom);
  endtask

  task automatic set_d(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic rw, input logic m2r, input logic mw, input logic as, input logic rdst);
    RD1D = a; RD2D = b; SignImmD = imm; rsD = rs; rtD = rt; rdD = rd;
    RegWriteD = rw; MemtoRegD = m2r; MemWriteD = mw; ALUSrcD = as; RegDstD = rdst;
    ALUControlD = 3'd2;
  endtask

  initial begin
    rst_n = 0; stallE = 0; flushE = 0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    ALUControlD = 0; forwardAE = 0; forwardBE = 0; ALUOutM = 0; ResultW = 0;
    tick(); tick();
    chk("rst_SrcAE", SrcAE, 32'h0);
    chk("rst_validE", 32'(validE), 32'h0);
    rst_n = 1;

    // Load
    set_d(32'h11, 32'h22, 32'hFFFFFFF0, 3, 4, 5, 1, 0, 0, 0, 1);
    tick();
    chk("ld_SrcAE", SrcAE, 32'h11);
    chk("ld_SrcBE", SrcBE, 32'h22);
    chk("ld_WriteDataE", WriteDataE, 32'h22);
    chk("ld_WriteRegE", 32'(WriteRegE), 32'd5);
    chk("ld_rsE", 32'(rsE), 32'd3);
    chk("ld_rtE", 32'(rtE), 32'd4);
    chk("ld_validE", 32'(validE), 32'd1);
    chk("ld_RegWriteE", 32'(RegWriteE), 32'd1);
    ALUSrcD = 1; RegDstD = 0;
    tick();
    chk("imm_SrcBE", SrcBE, 32'hFFFFFFF0);
    chk("rt_WriteRegE", 32'(WriteRegE), 32'd4);
    ALUSrcD = 0; RegDstD = 1;
    tick();

    // Forwarding, state held by stall so nothing reloads
    stallE = 1; ALUOutM = 32'hAAAA; ResultW = 32'hBBBB;
    forwardAE = 2'b10; forwardBE = 2'b01; #1;
    chk("fwd_SrcAE_M", SrcAE, 32'hAAAA);
    chk("fwd_WD_W", WriteDataE, 32'hBBBB);
    chk("fwd_SrcBE_W", SrcBE, 32'hBBBB);
    forwardAE = 2'b11; #1;
    chk("fwd_reserved", SrcAE, 32'h11);
    forwardAE = 2'b10; ALUOutM = 32'hCCCC; #1;
    chk("fwd_comb", SrcAE, 32'hCCCC);
    forwardAE = 0; forwardBE = 0;

    // Stall for three edges with changing decode inputs
    for (int i = 0; i < 3; i++) begin
      rand_decode();
      tick();
      chk("stall_SrcAE", SrcAE, 32'h11);
      chk("stall_SrcBE", SrcBE, 32'h22);
      chk("stall_WriteRegE", 32'(WriteRegE), 32'd5);
      chk("stall_rsE", 32'(rsE), 32'd3);
    end
    stallE = 0;
    set_d(32'h55, 32'h66, 32'h7, 6, 7, 9, 1, 0, 1, 0, 1);
    tick();
    chk("rel_SrcAE", SrcAE, 32'h55);
    chk("rel_WriteRegE", 32'(WriteRegE), 32'd9);

    // Flush wins over stall
    flushE = 1; stallE = 1; RegWriteD = 1; MemWriteD = 1;
    tick();
    chk("fl_RegWriteE", 32'(RegWriteE), 32'd0);
    chk("fl_MemWriteE", 32'(MemWriteE), 32'd0);
    chk("fl_rsE", 32'(rsE), 32'd0);
    chk("fl_rtE", 32'(rtE), 32'd0);
    chk("fl_WriteRegE", 32'(WriteRegE), 32'd0);
    chk("fl_validE", 32'(validE), 32'd0);
    chk("fl_SrcAE", SrcAE, 32'd0);

    // Load-use: lw r8 then dependent add with one bubble
    flushE = 0; stallE = 0;
    set_d(32'h100, 32'h0, 32'h4, 2, 8, 0, 1, 1, 0, 1, 0);
    tick();
    chk("lw_WriteRegE", 32'(WriteRegE), 32'd8);
    chk("lw_MemtoRegE", 32'(MemtoRegE), 32'd1);
    set_d(32'h0, 32'h3, 32'h0, 8, 9, 10, 1, 0, 0, 0, 1);
    flushE = 1;
    tick();
    chk("lu_bubble", 32'(validE), 32'd0);
    flushE = 0;
    tick();
    chk("lu_rsE", 32'(rsE), 32'd8);
    chk("lu_validE", 32'(validE), 32'd1);
    forwardAE = 2'b01; ResultW = 32'h1234; #1;
    chk("lu_SrcAE", SrcAE, 32'h1234);
    chk("lu_WriteRegE", 32'(WriteRegE), 32'd10);
    forwardAE = 0;

    // Asynchronous reset in mid-cycle, then normal load on the next edge
    @(posedge clk); #3;
    rst_n = 0; #1;
    chk("ar_SrcAE", SrcAE, 32'h0);
    chk("ar_SrcBE", SrcBE, 32'h0);
    chk("ar_WriteDataE", WriteDataE, 32'h0);
    chk("ar_WriteRegE", 32'(WriteRegE), 32'h0);
    chk("ar_validE", 32'(validE), 32'h0);
    #4 rst_n = 1;
    tick();
    chk("ar_reload", 32'(validE), 32'd1);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      rand_decode();
      stallE = ($urandom_range(0, 3) == 0);
      flushE = ($urandom_range(0, 7) == 0);
      forwardAE = 2'($urandom); forwardBE = 2'($urandom);
      ALUOutM = $urandom; ResultW = $urandom;
      rst_n = ($urandom_range(0, 49) != 0);
      tick();
    end
    rst_n = 1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
